// File: rtl/mem_dma.sv
// Word-granular DMA engine: copies a block of words or fills a region with a constant
// pattern through the shared single-port data memory (async read, sync write).
module mem_dma #(
    parameter int unsigned LEN_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      fill_data,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] count,
    output logic             r_en,
    output logic             w_en,
    output logic [31:0]      addr,
    output logic [31:0]      wdata,
    input  logic [31:0]      rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite
    } state_t;

    state_t             state;
    logic               mode_fill;
    logic [31:0]        src_base;
    logic [31:0]        dst_base;
    logic [LEN_W-1:0]   len_reg;
    logic [31:0]        fill_reg;
    logic [LEN_W-1:0]   idx;
    logic [LEN_W-1:0]   idx_next;
    logic               last;

    always_comb begin
        idx_next = idx + 1'b1;
        last     = (idx_next == len_reg);
    end

    // All memory-side outputs are registers, set up one edge ahead of the cycle they
    // describe, so they never glitch and the async reset clears them immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            mode_fill <= 1'b0;
            src_base  <= '0;
            dst_base  <= '0;
            len_reg   <= '0;
            fill_reg  <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            r_en      <= 1'b0;
            w_en      <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        mode_fill <= mode;
                        src_base  <= src_addr;
                        dst_base  <= dst_addr;
                        len_reg   <= len;
                        fill_reg  <= fill_data;
                        idx       <= '0;
                        count     <= '0;
                        if (len == '0) begin
                            done <= 1'b1;
                        end else if (mode) begin
                            state <= StWrite;
                            busy  <= 1'b1;
                            w_en  <= 1'b1;
                            addr  <= dst_addr;
                            wdata <= fill_data;
                        end else begin
                            state <= StRead;
                            busy  <= 1'b1;
                            r_en  <= 1'b1;
                            addr  <= src_addr;
                        end
                    end
                end

                StRead: begin
                    r_en <= 1'b0;
                    if (abort) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        addr  <= '0;
                        wdata <= '0;
                    end else begin
                        // wdata doubles as the data register holding the word just read
                        state <= StWrite;
                        w_en  <= 1'b1;
                        addr  <= dst_base + 32'(idx);
                        wdata <= rdata;
                    end
                end

                StWrite: begin
                    // The write of this cycle always lands, so it is counted even on abort
                    count <= count + 1'b1;
                    idx   <= idx_next;
                    if (last || abort) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        done  <= ~abort;
                        w_en  <= 1'b0;
                        addr  <= '0;
                        wdata <= '0;
                    end else if (mode_fill) begin
                        addr  <= dst_base + 32'(idx_next);
                        wdata <= fill_reg;
                    end else begin
                        state <= StRead;
                        w_en  <= 1'b0;
                        r_en  <= 1'b1;
                        addr  <= src_base + 32'(idx_next);
                        wdata <= '0;
                    end
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    r_en  <= 1'b0;
                    w_en  <= 1'b0;
                    addr  <= '0;
                    wdata <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// Scoreboard bench for mem_dma: stimulus pushes expected memory accesses and done pulses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_dma;

    localparam int unsigned LEN_W = 11;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             mode;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic [31:0]      fill_data;
    logic             abort;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] count;
    logic             r_en;
    logic             w_en;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;

    mem_dma #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_data (fill_data),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .r_en      (r_en),
        .w_en      (w_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    // 256-word memory model, aliased on the low address byte
    logic [31:0] mem [256];
    always_comb rdata = mem[addr[7:0]];
    always @(posedge clk) if (w_en) mem[addr[7:0]] <= wdata;

    typedef struct {
        int          kind;  // 0 read, 1 write, 2 done
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  n_pass = 0;
    int  n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            if (r_en && w_en) check("rd_wr_exclusive", {r_en, w_en}, 2'b10);
            if (r_en || w_en || done) begin
                check("event_expected", 64'(exp_q.size() == 0), 64'd0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (r_en) begin
                        check("read_kind", 64'(e.kind), 64'd0);
                        check("read_addr", addr, e.a);
                    end else if (w_en) begin
                        check("write_kind", 64'(e.kind), 64'd1);
                        check("write_addr", addr, e.a);
                        check("write_data", wdata, e.d);
                    end else begin
                        check("done_kind", 64'(e.kind), 64'd2);
                        check("done_count", 64'(count), e.d);
                        check("done_not_busy", 64'(busy), 64'd0);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues start at edge E0; returns in the done cycle (or after the budget) with the
    // cycle offset of done (0 = none) and the number of busy cycles seen.
    task automatic run(input bit m, input logic [31:0] s, input logic [31:0] d,
                       input logic [LEN_W-1:0] n, input logic [31:0] f,
                       input int abort_at, input int poke_at,
                       output int done_cyc, output int busy_cyc);
        mode = m; src_addr = s; dst_addr = d; len = n; fill_data = f;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_cyc = 0;
        busy_cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = k;
                break;
            end
            abort = (k == abort_at);
            start = (k == poke_at);
            if (k == poke_at) begin
                mode = 1'b1; dst_addr = 32'h90; len = 5; fill_data = 32'hBAD;
            end
            tick();
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    int dc, bc;

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_data = '0; abort = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 8; i++) mem[8'h10 + i] = 32'hA0 + i;
        mem[8'h63] = 32'h1234;
        mem[8'h20] = 32'h5;
        for (int i = 1; i < 4; i++) mem[8'h20 + i] = 32'h99;
        mem[8'h70] = 32'h4321;

        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_r_en", r_en, 0);
        check("rst_w_en", w_en, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_count", count, 0);
        reset = 1'b0;
        tick();

        // Copy 4 words 0x10 -> 0x40
        for (int i = 0; i < 4; i++) begin
            push(0, 32'h10 + i, 0);
            push(1, 32'h40 + i, 32'hA0 + i);
        end
        push(2, 0, 4);
        run(1'b0, 32'h10, 32'h40, 4, 0, 0, 0, dc, bc);
        check("copy_done_cycle", dc, 9);
        check("copy_busy_cycles", bc, 8);
        check("copy_count", count, 4);
        for (int i = 0; i < 4; i++) check("copy_mem", mem[8'h40 + i], 32'hA0 + i);
        tick();

        // Fill 3 words at 0x80
        for (int i = 0; i < 3; i++) push(1, 32'h80 + i, 32'hDEADBEEF);
        push(2, 0, 3);
        run(1'b1, 32'h0, 32'h80, 3, 32'hDEADBEEF, 0, 0, dc, bc);
        check("fill_done_cycle", dc, 4);
        check("fill_busy_cycles", bc, 3);
        tick();

        // Zero length
        push(2, 0, 0);
        run(1'b0, 32'h10, 32'h40, 0, 0, 0, 0, dc, bc);
        check("zero_done_cycle", dc, 1);
        check("zero_busy_cycles", bc, 0);
        tick();

        // Start pulsed mid-transfer is ignored
        for (int i = 0; i < 2; i++) begin
            push(0, 32'h10 + i, 0);
            push(1, 32'h50 + i, 32'hA0 + i);
        end
        push(2, 0, 2);
        run(1'b0, 32'h10, 32'h50, 2, 0, 0, 2, dc, bc);
        check("ignore_done_cycle", dc, 5);
        repeat (8) tick();
        check("ignore_idle", busy, 0);
        check("ignore_no_fill", mem[8'h90], 0);

        // Abort during the 3rd WRITE of an 8-word copy
        for (int i = 0; i < 3; i++) begin
            push(0, 32'h10 + i, 0);
            push(1, 32'h60 + i, 32'hA0 + i);
        end
        run(1'b0, 32'h10, 32'h60, 8, 0, 6, 0, dc, bc);
        check("abort_no_done", dc, 0);
        check("abort_busy_cycles", bc, 6);
        check("abort_count", count, 3);
        check("abort_mem2", mem[8'h62], 32'hA2);
        check("abort_untouched", mem[8'h63], 32'h1234);

        // Overlapping copy propagates the first word
        for (int i = 0; i < 3; i++) begin
            push(0, 32'h20 + i, 0);
            push(1, 32'h21 + i, 32'h5);
        end
        push(2, 0, 3);
        run(1'b0, 32'h20, 32'h21, 3, 0, 0, 0, dc, bc);
        for (int i = 1; i < 4; i++) check("overlap_mem", mem[8'h20 + i], 32'h5);
        tick();

        // Fill across the top of the address space
        push(1, 32'hFFFFFFFF, 32'h77);
        push(1, 32'h00000000, 32'h77);
        push(2, 0, 2);
        run(1'b1, 32'h0, 32'hFFFFFFFF, 2, 32'h77, 0, 0, dc, bc);
        check("wrap_done_cycle", dc, 3);
        tick();

        // Back-to-back start issued in the done cycle
        push(1, 32'h30, 32'h11);
        push(2, 0, 1);
        push(1, 32'h31, 32'h55);
        push(1, 32'h32, 32'h55);
        push(2, 0, 2);
        run(1'b1, 32'h0, 32'h30, 1, 32'h11, 0, 0, dc, bc);
        check("b2b_first_done", dc, 2);
        run(1'b1, 32'h0, 32'h31, 2, 32'h55, 0, 0, dc, bc);
        check("b2b_second_done", dc, 3);
        tick();

        // Asynchronous reset in the middle of a READ
        mode = 1'b0; src_addr = 32'h10; dst_addr = 32'h70; len = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("pre_reset_r_en", r_en, 1);
        reset = 1'b1;
        #1;
        check("areset_r_en", r_en, 0);
        check("areset_w_en", w_en, 0);
        check("areset_busy", busy, 0);
        check("areset_addr", addr, 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("areset_mem", mem[8'h70], 32'h4321);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
